// File: rtl/mips_16_boot_ctrl_pkg.sv
// Shared definitions for the mips_16 boot/debug sequencer: host command codes,
// header field helpers and FSM state encoding.
package mips_16_boot_ctrl_pkg;

  typedef enum logic [3:0] {
    CmdLoadImem = 4'd1,
    CmdLoadDmem = 4'd2,
    CmdRun      = 4'd3,
    CmdHalt     = 4'd4,
    CmdClearRf  = 4'd5
  } boot_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StClear,
    StRun
  } boot_state_e;

  localparam int unsigned HdrCmdLsb = 12;
  localparam int unsigned HdrLenW   = 12;

  function automatic logic [3:0] hdr_cmd(input logic [15:0] w);
    return w[15:HdrCmdLsb];
  endfunction

  function automatic logic [HdrLenW-1:0] hdr_len(input logic [15:0] w);
    return w[HdrLenW-1:0];
  endfunction

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c >= CmdLoadImem) && (c <= CmdClearRf);
  endfunction

endpackage

// File: rtl/mips_16_boot_ctrl_if.sv
// Host word stream into the boot sequencer: valid/ready handshake with a 16-bit payload.
interface mips_16_boot_ctrl_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mips_16_boot_ctrl.sv
// Boot/debug sequencer: holds the core in reset, loads IMEM/DMEM, clears the RF
// from a host word stream, and releases the core on RUN until HALT.
module mips_16_boot_ctrl
  import mips_16_boot_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned DMEM_AW  = 8,
  parameter int unsigned REG_NUM  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_16_boot_ctrl_if.slave        host,
  output logic                      core_rst,
  output logic                      imem_write_en,
  output logic [PC_WIDTH-1:0]       imem_write_addr,
  output logic [15:0]               imem_write_data,
  output logic                      mem_sel,
  output logic                      dmem_write_en,
  output logic [15:0]               dmem_addr,
  output logic [15:0]               dmem_write_data,
  output logic                      rf_write_en,
  output logic [2:0]                rf_write_dest,
  output logic                      running,
  output logic                      cmd_err
);

  localparam int unsigned AddrW = (PC_WIDTH > DMEM_AW) ? PC_WIDTH : DMEM_AW;
  localparam int unsigned ClrW  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [AddrW-1:0] ImemMask = AddrW'((64'd1 << PC_WIDTH) - 64'd1);
  localparam logic [AddrW-1:0] DmemMask = AddrW'((64'd1 << DMEM_AW) - 64'd1);
  localparam logic [ClrW-1:0]  ClrLast  = ClrW'(REG_NUM - 1);

  boot_state_e        state_q, state_d;
  logic               dsel_q, dsel_d;
  logic [HdrLenW-1:0] cnt_q, cnt_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [ClrW-1:0]    clr_q, clr_d;
  logic               imem_we_q, imem_we_d;
  logic               dmem_we_q, dmem_we_d;
  logic [AddrW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               cmd_err_q, cmd_err_d;

  logic             beat;
  logic [3:0]       cmd;
  logic [AddrW-1:0] wrap_mask;

  assign beat      = host.valid & host.ready;
  assign cmd       = hdr_cmd(host.data);
  assign wrap_mask = dsel_q ? DmemMask : ImemMask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          case (cmd)
            CmdLoadImem, CmdLoadDmem: state_d = StAddr;
            CmdClearRf:               state_d = StClear;
            CmdRun:                   state_d = StRun;
            default:                  state_d = StIdle;
          endcase
        end
      end
      StAddr:  if (beat) state_d = (cnt_q != '0) ? StData : StIdle;
      StData:  if (beat && cnt_q == HdrLenW'(1)) state_d = StIdle;
      StClear: if (clr_q == ClrLast) state_d = StIdle;
      StRun:   if (beat && cmd == CmdHalt) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_rst      = 1'b1;
    mem_sel       = 1'b1;
    running       = 1'b0;
    host.ready    = 1'b1;
    rf_write_en   = 1'b0;
    rf_write_dest = '0;
    unique case (state_q)
      StClear: begin
        host.ready    = 1'b0;
        rf_write_en   = 1'b1;
        rf_write_dest = 3'(clr_q);
      end
      StRun: begin
        core_rst = 1'b0;
        mem_sel  = 1'b0;
        running  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: counters plus the registered write port (one cycle behind the beat).
  always_comb begin
    dsel_d    = dsel_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    clr_d     = '0;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cmd_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          dsel_d    = (cmd == CmdLoadDmem);
          cnt_d     = hdr_len(host.data);
          cmd_err_d = ~cmd_legal(cmd);
        end
      end
      StAddr: if (beat) addr_d = host.data[AddrW-1:0] & wrap_mask;
      StData: begin
        if (beat) begin
          imem_we_d = ~dsel_q;
          dmem_we_d = dsel_q;
          wr_addr_d = addr_q;
          wr_data_d = host.data;
          addr_d    = (addr_q + AddrW'(1)) & wrap_mask;
          cnt_d     = cnt_q - HdrLenW'(1);
        end
      end
      StClear: clr_d = clr_q + ClrW'(1);
      StRun:   if (beat && cmd != CmdHalt) cmd_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsel_q    <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      clr_q     <= '0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      dsel_q    <= dsel_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      clr_q     <= clr_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign imem_write_en   = imem_we_q;
  assign imem_write_addr = wr_addr_q[PC_WIDTH-1:0];
  assign imem_write_data = wr_data_q;
  assign dmem_write_en   = dmem_we_q;
  assign dmem_addr       = 16'(wr_addr_q[DMEM_AW-1:0]);
  assign dmem_write_data = wr_data_q;
  assign cmd_err         = cmd_err_q;

endmodule
